// File: rtl/uart_pkg.sv
// Shared types and constants for the UART IP.
// The receive FIFO entry keeps the error flags alongside the byte they belong to.
package uart_pkg;

  localparam int RX_FIFO_DEPTH_DEFAULT = 16;

  typedef struct packed {
    logic       ferr;
    logic       perr;
    logic [7:0] data;
  } rx_entry_t;

endpackage

// File: rtl/uart_fifo_ram.sv
// Register-array storage for the receive FIFO.
// One write port and one asynchronous read port; the contents are never reset.
module uart_fifo_ram
  import uart_pkg::*;
#(
  parameter int DEPTH = RX_FIFO_DEPTH_DEFAULT,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  rx_entry_t       wdata_i,
  input  logic [AW-1:0]   raddr_i,
  output rx_entry_t       rdata_o
);

  rx_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // The read is combinational so the head entry is visible without a pop.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO for uart_ip: show-ahead pop port, fill level, threshold
// interrupt, sticky overflow and an idle-line timeout.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH          = RX_FIFO_DEPTH_DEFAULT,
  parameter int TIMEOUT_CYCLES = 20832
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_valid,
  input  logic [7:0]               wr_data,
  input  logic                     wr_perr,
  input  logic                     wr_ferr,
  input  logic                     rd_en,
  output logic [7:0]               rd_data,
  output logic                     rd_perr,
  output logic                     rd_ferr,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  input  logic [$clog2(DEPTH):0]   thresh,
  output logic                     thr_irq,
  output logic                     overflow,
  input  logic                     ovf_clr,
  output logic                     rx_timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] FULL_LEVEL = CW'(DEPTH);
  localparam logic [TW-1:0] TMO_MAX    = TW'(TIMEOUT_CYCLES);

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          ovf_q, ovf_d;

  logic          is_empty, is_full;
  logic          push, pop, drop;
  rx_entry_t     wr_entry, head_entry;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == FULL_LEVEL);

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
  assign pop  = rd_en && !is_empty;
  assign push = wr_valid && (!is_full || pop);
  assign drop = wr_valid && is_full && !pop;

  assign wr_entry = '{ferr: wr_ferr, perr: wr_perr, data: wr_data};

  uart_fifo_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (push && !flush),
    .waddr_i (wptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rptr_q),
    .rdata_o (head_entry)
  );

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    tmo_d   = tmo_q;
    ovf_d   = ovf_q;

    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end

    // A dropped write is neither activity nor idle time: the counter holds.
    if (flush || push || pop || is_empty) begin
      tmo_d = '0;
    end else if (!wr_valid && (tmo_q != TMO_MAX)) begin
      tmo_d = tmo_q + TW'(1);
    end

    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      tmo_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      tmo_q   <= tmo_d;
      ovf_q   <= ovf_d;
    end
  end

  assign empty      = is_empty;
  assign full       = is_full;
  assign count      = count_q;
  assign thr_irq    = (thresh != '0) && (count_q >= thresh);
  assign overflow   = ovf_q;
  assign rx_timeout = (tmo_q == TMO_MAX);

  assign rd_data = is_empty ? 8'h00 : head_entry.data;
  assign rd_perr = is_empty ? 1'b0  : head_entry.perr;
  assign rd_ferr = is_empty ? 1'b0  : head_entry.ferr;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH=16, TIMEOUT_CYCLES=100).
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst, flush, wr_valid, wr_perr, wr_ferr, rd_en, ovf_clr;
  logic [7:0] wr_data;
  logic [4:0] thresh;
  logic [7:0] rd_data;
  logic       rd_perr, rd_ferr, empty, full, thr_irq, overflow, rx_timeout;
  logic [4:0] count;

  int checks = 0;
  int errors = 0;

  uart_rx_fifo #(.DEPTH(16), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .flush(flush), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_perr(wr_perr), .wr_ferr(wr_ferr), .rd_en(rd_en), .rd_data(rd_data),
    .rd_perr(rd_perr), .rd_ferr(rd_ferr), .empty(empty), .full(full), .count(count),
    .thresh(thresh), .thr_irq(thr_irq), .overflow(overflow), .ovf_clr(ovf_clr),
    .rx_timeout(rx_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic p, input logic f);
    wr_valid = 1'b1; wr_data = d; wr_perr = p; wr_ferr = f;
    tick();
    wr_valid = 1'b0; wr_data = 8'h00; wr_perr = 1'b0; wr_ferr = 1'b0;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if ({empty, full, count, rd_data, rd_perr, rd_ferr, thr_irq, overflow, rx_timeout}
        !== {1'b1, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: empty=%0b full=%0b count=%0d rd_data=%02h ovf=%0b tmo=%0b required empty=1 full=0 count=0 rd_data=00 ovf=0 tmo=0",
               empty, full, count, rd_data, overflow, rx_timeout);
    end
    $display("reset: empty=%0b count=%0d rd_data=%02h", empty, count, rd_data);
  endtask

  task automatic test_push_pop();
    push(8'hA5, 1'b1, 1'b0);
    checks++;
    if ({rd_data, rd_perr, rd_ferr, count, empty} !== {8'hA5, 1'b1, 1'b0, 5'd1, 1'b0}) begin
      errors++;
      $display("FAIL push_head: rd_data=%02h perr=%0b ferr=%0b count=%0d empty=%0b required A5 1 0 1 0",
               rd_data, rd_perr, rd_ferr, count, empty);
    end
    $display("push A5 perr=1: rd_data=%02h perr=%0b count=%0d", rd_data, rd_perr, count);
    pop();
    checks++;
    if ({empty, count, rd_data, rd_perr} !== {1'b1, 5'd0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL pop_empty: empty=%0b count=%0d rd_data=%02h perr=%0b required 1 0 00 0",
               empty, count, rd_data, rd_perr);
    end
    $display("pop: empty=%0b count=%0d", empty, count);
    // Pop while empty has no side effect.
    pop();
    checks++;
    if ({empty, count} !== {1'b1, 5'd0}) begin
      errors++;
      $display("FAIL pop_while_empty: empty=%0b count=%0d required 1 0", empty, count);
    end
  endtask

  task automatic test_full_overflow();
    for (int i = 0; i < 16; i++) push(8'(i), 1'b0, 1'(i % 2));
    checks++;
    if ({full, count, overflow} !== {1'b1, 5'd16, 1'b0}) begin
      errors++;
      $display("FAIL fill16: full=%0b count=%0d ovf=%0b required 1 16 0", full, count, overflow);
    end
    $display("fill 00..0F: full=%0b count=%0d", full, count);
    // Drop coinciding with ovf_clr: the set wins.
    ovf_clr = 1'b1;
    push(8'h55, 1'b0, 1'b0);
    ovf_clr = 1'b0;
    checks++;
    if ({overflow, count, full} !== {1'b1, 5'd16, 1'b1}) begin
      errors++;
      $display("FAIL drop_55: ovf=%0b count=%0d full=%0b required 1 16 1", overflow, count, full);
    end
    $display("push 55 while full: ovf=%0b count=%0d", overflow, count);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if ({rd_data, rd_ferr} !== {8'(i), 1'(i % 2)}) begin
        errors++;
        $display("FAIL drain_%0d: rd_data=%02h ferr=%0b required %02h %0b",
                 i, rd_data, rd_ferr, 8'(i), 1'(i % 2));
      end
      $display("pop %0d: rd_data=%02h ferr=%0b", i, rd_data, rd_ferr);
      pop();
    end
    checks++;
    if ({empty, overflow} !== {1'b1, 1'b1}) begin
      errors++;
      $display("FAIL drained: empty=%0b ovf=%0b required 1 1", empty, overflow);
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clr: ovf=%0b required 0", overflow);
    end
    $display("ovf_clr: ovf=%0b", overflow);
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 16; i++) push(8'h10 + 8'(i), 1'b0, 1'b0);
    rd_en = 1'b1;
    push(8'h77, 1'b0, 1'b0);
    rd_en = 1'b0;
    checks++;
    if ({count, full, overflow} !== {5'd16, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL full_push_pop: count=%0d full=%0b ovf=%0b required 16 1 0", count, full, overflow);
    end
    $display("full + push 77 + pop: count=%0d ovf=%0b", count, overflow);
    for (int i = 1; i <= 16; i++) begin
      logic [7:0] exp;
      exp = (i == 16) ? 8'h77 : 8'h10 + 8'(i);
      checks++;
      if (rd_data !== exp) begin
        errors++;
        $display("FAIL fpp_drain_%0d: rd_data=%02h required %02h", i, rd_data, exp);
      end
      pop();
    end
    $display("drain after simultaneous push/pop: empty=%0b", empty);
  endtask

  task automatic test_threshold();
    thresh = 5'd4;
    for (int i = 0; i < 3; i++) begin
      push(8'hC0 + 8'(i), 1'b0, 1'b0);
      checks++;
      if (thr_irq !== 1'b0) begin
        errors++;
        $display("FAIL thr_below_%0d: thr_irq=%0b required 0", i, thr_irq);
      end
    end
    push(8'hC3, 1'b0, 1'b0);
    checks++;
    if (thr_irq !== 1'b1) begin
      errors++;
      $display("FAIL thr_at4: thr_irq=%0b required 1", thr_irq);
    end
    $display("thresh=4 count=%0d: thr_irq=%0b", count, thr_irq);
    pop();
    checks++;
    if (thr_irq !== 1'b0) begin
      errors++;
      $display("FAIL thr_after_pop: thr_irq=%0b required 0", thr_irq);
    end
    $display("pop to count=%0d: thr_irq=%0b", count, thr_irq);
    thresh = 5'd0;
    tick();
    checks++;
    if (thr_irq !== 1'b0) begin
      errors++;
      $display("FAIL thr_zero: thr_irq=%0b required 0", thr_irq);
    end
    do_flush();
  endtask

  task automatic test_timeout();
    push(8'h42, 1'b0, 1'b0);
    for (int i = 0; i < 99; i++) tick();
    checks++;
    if (rx_timeout !== 1'b0) begin
      errors++;
      $display("FAIL tmo_99: rx_timeout=%0b required 0", rx_timeout);
    end
    tick();
    checks++;
    if (rx_timeout !== 1'b1) begin
      errors++;
      $display("FAIL tmo_100: rx_timeout=%0b required 1", rx_timeout);
    end
    $display("idle 100 cycles: rx_timeout=%0b", rx_timeout);
    tick();
    checks++;
    if (rx_timeout !== 1'b1) begin
      errors++;
      $display("FAIL tmo_sat: rx_timeout=%0b required 1", rx_timeout);
    end
    pop();
    checks++;
    if (rx_timeout !== 1'b0) begin
      errors++;
      $display("FAIL tmo_pop: rx_timeout=%0b required 0", rx_timeout);
    end
    $display("pop: rx_timeout=%0b", rx_timeout);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) push(8'hE0 + 8'(i), 1'b0, 1'b0);
    flush = 1'b1;
    push(8'hEE, 1'b0, 1'b0);
    flush = 1'b0;
    checks++;
    if ({empty, count, rd_data} !== {1'b1, 5'd0, 8'h00}) begin
      errors++;
      $display("FAIL flush: empty=%0b count=%0d rd_data=%02h required 1 0 00", empty, count, rd_data);
    end
    $display("flush with wr_valid: empty=%0b count=%0d", empty, count);
    push(8'h3C, 1'b0, 1'b0);
    checks++;
    if ({rd_data, count} !== {8'h3C, 5'd1}) begin
      errors++;
      $display("FAIL after_flush: rd_data=%02h count=%0d required 3C 1", rd_data, count);
    end
    $display("push 3C after flush: rd_data=%02h count=%0d", rd_data, count);
    pop();
  endtask

  task automatic test_reset_midop();
    for (int i = 0; i < 3; i++) push(8'hB0 + 8'(i), 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({empty, count} !== {1'b1, 5'd0}) begin
      errors++;
      $display("FAIL midop_reset: empty=%0b count=%0d required 1 0", empty, count);
    end
    push(8'h9E, 1'b0, 1'b1);
    checks++;
    if ({rd_data, rd_ferr, count} !== {8'h9E, 1'b1, 5'd1}) begin
      errors++;
      $display("FAIL midop_push: rd_data=%02h ferr=%0b count=%0d required 9E 1 1", rd_data, rd_ferr, count);
    end
    $display("reset mid-op then push 9E: rd_data=%02h count=%0d", rd_data, count);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; wr_valid = 1'b0; wr_data = 8'h00; wr_perr = 1'b0;
    wr_ferr = 1'b0; rd_en = 1'b0; ovf_clr = 1'b0; thresh = 5'd0;
    test_reset();
    test_push_pop();
    test_full_overflow();
    test_full_push_pop();
    test_threshold();
    test_timeout();
    test_flush();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
